// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: steps a small combinational block through every
// input vector, samples its output and scores the observed table against an expected one.
module truth_table_sweeper #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      dut_in,
  input  logic                 dut_f,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic                 pass,
  output logic [N_IN:0]        mismatch_cnt,
  output logic [N_IN-1:0]      first_fail_idx,
  output logic                 first_fail_valid
);

  localparam int NV = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NV - 1);
  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_SAMPLE,
    S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [NV-1:0]     exp_q, exp_d;
  logic [N_IN-1:0]   dut_in_q, dut_in_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [NV-1:0]     table_q, table_d;
  logic              pass_q, pass_d;
  logic [N_IN:0]     mm_q, mm_d;
  logic [N_IN-1:0]   ffi_q, ffi_d;
  logic              ffv_q, ffv_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    dut_in_d = dut_in_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    table_d  = table_q;
    pass_d   = pass_q;
    mm_d     = mm_q;
    ffi_d    = ffi_q;
    ffv_d    = ffv_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          exp_d    = expected;
          table_d  = '0;
          mm_d     = '0;
          ffi_d    = '0;
          ffv_d    = 1'b0;
          pass_d   = 1'b0;
          dut_in_d = '0;
          busy_d   = 1'b1;
          cnt_d    = SETTLE_C;
          state_d  = (SETTLE > 0) ? S_HOLD : S_SAMPLE;
        end
      end
      S_HOLD: begin
        if (abort) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          dut_in_d = '0;
          pass_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (abort) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          dut_in_d = '0;
          pass_d   = 1'b0;
        end else begin
          table_d[dut_in_q] = dut_f;
          if (dut_f != exp_q[dut_in_q]) begin
            mm_d = mm_q + 1'b1;
            if (!ffv_q) begin
              ffi_d = dut_in_q;
              ffv_d = 1'b1;
            end
          end
          // Pass is judged on the count including this final sample.
          if (dut_in_q == LAST_VEC) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (mm_d == '0);
          end else begin
            dut_in_d = dut_in_q + 1'b1;
            cnt_d    = SETTLE_C;
            state_d  = (SETTLE > 0) ? S_HOLD : S_SAMPLE;
          end
        end
      end
      S_FINISH: begin
        dut_in_d = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      exp_q    <= '0;
      dut_in_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      table_q  <= '0;
      pass_q   <= 1'b0;
      mm_q     <= '0;
      ffi_q    <= '0;
      ffv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      dut_in_q <= dut_in_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      table_q  <= table_d;
      pass_q   <= pass_d;
      mm_q     <= mm_d;
      ffi_q    <= ffi_d;
      ffv_q    <= ffv_d;
    end
  end

  assign dut_in           = dut_in_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign table_out        = table_q;
  assign pass             = pass_q;
  assign mismatch_cnt     = mm_q;
  assign first_fail_idx   = ffi_q;
  assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: three instances (SETTLE 1, 3, 0) driving a majority
// gate model; a scoreboard of predicted results is checked at each done pulse.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       abort = 1'b0;
  logic       stuck = 1'b0;
  logic [7:0] expected = 8'h00;
  logic [2:0] start_v = 3'b000;

  logic [2:0] busy_v, done_v, pass_v, ffv_v, f_v;
  logic [2:0] dut_in_a [3];
  logic [7:0] table_a  [3];
  logic [3:0] mm_a     [3];
  logic [2:0] ffi_a    [3];

  typedef struct {
    logic [7:0] tab;
    logic [3:0] cnt;
    logic [2:0] idx;
    logic       valid;
    logic       pass_e;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic maj(input logic [2:0] v);
    return (v[2] & v[1]) | (v[1] & v[0]) | (v[2] & v[0]);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      assign f_v[gi] = stuck ? 1'b0 : maj(dut_in_a[gi]);
      truth_table_sweeper #(
        .N_IN  (3),
        .SETTLE((gi == 0) ? 1 : ((gi == 1) ? 3 : 0))
      ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start_v[gi]),
        .abort           (abort),
        .expected        (expected),
        .dut_in          (dut_in_a[gi]),
        .dut_f           (f_v[gi]),
        .busy            (busy_v[gi]),
        .done            (done_v[gi]),
        .table_out       (table_a[gi]),
        .pass            (pass_v[gi]),
        .mismatch_cnt    (mm_a[gi]),
        .first_fail_idx  (ffi_a[gi]),
        .first_fail_valid(ffv_v[gi])
      );
    end
  endgenerate

  // Called at a negedge; returns at the negedge of cycle 1 (start accepted at edge 0).
  task automatic launch(input int w, input logic [7:0] exp_tab, input bit push);
    exp_t e;
    logic f;
    e.tab = 8'h00; e.cnt = 4'd0; e.idx = 3'd0; e.valid = 1'b0;
    for (int v = 0; v < 8; v++) begin
      f = stuck ? 1'b0 : maj(3'(v));
      e.tab[v] = f;
      if (f != exp_tab[v]) begin
        e.cnt = e.cnt + 4'd1;
        if (!e.valid) begin
          e.idx = 3'(v);
          e.valid = 1'b1;
        end
      end
    end
    e.pass_e = (e.cnt == 4'd0);
    if (push) sb.push_back(e);
    expected = exp_tab;
    start_v[w] = 1'b1;
    @(negedge clk);
    start_v[w] = 1'b0;
  endtask

  task automatic watch_sweep(input int w, input int settle, input int restart_cyc,
                             input logic [7:0] new_exp, input string tag);
    int total;
    exp_t e;
    logic [2:0] di_exp;
    total = 8 * (settle + 1);
    for (int cyc = 1; cyc <= total + 2; cyc++) begin
      n_cmp++;
      if (busy_v[w] !== (cyc <= total)) begin
        n_bad++;
        $display("FAIL %s busy cyc=%0d got=%b want=%b", tag, cyc, busy_v[w], (cyc <= total));
      end
      n_cmp++;
      if (done_v[w] !== (cyc == total + 1)) begin
        n_bad++;
        $display("FAIL %s done cyc=%0d got=%b want=%b", tag, cyc, done_v[w], (cyc == total + 1));
      end
      di_exp = (cyc <= total) ? 3'((cyc - 1) / (settle + 1)) : ((cyc == total + 1) ? 3'd7 : 3'd0);
      n_cmp++;
      if (dut_in_a[w] !== di_exp) begin
        n_bad++;
        $display("FAIL %s dut_in cyc=%0d got=%0d want=%0d", tag, cyc, dut_in_a[w], di_exp);
      end
      if (cyc == total + 1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL %s scoreboard empty at done", tag);
        end else begin
          e = sb.pop_front();
          if (table_a[w] !== e.tab || mm_a[w] !== e.cnt || ffi_a[w] !== e.idx ||
              ffv_v[w] !== e.valid || pass_v[w] !== e.pass_e) begin
            n_bad++;
            $display("FAIL %s result got tab=%h cnt=%0d idx=%0d v=%b p=%b want tab=%h cnt=%0d idx=%0d v=%b p=%b",
                     tag, table_a[w], mm_a[w], ffi_a[w], ffv_v[w], pass_v[w],
                     e.tab, e.cnt, e.idx, e.valid, e.pass_e);
          end else begin
            $display("%s: done cyc=%0d tab=%h cnt=%0d idx=%0d valid=%b pass=%b",
                     tag, cyc, table_a[w], mm_a[w], ffi_a[w], ffv_v[w], pass_v[w]);
          end
        end
      end
      if (cyc == restart_cyc) begin
        start_v[w] = 1'b1;
        expected = new_exp;
      end else begin
        start_v[w] = 1'b0;
      end
      @(negedge clk);
    end
    start_v[w] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      n_cmp++;
      if ({busy_v[w], done_v[w], pass_v[w], ffv_v[w], dut_in_a[w], table_a[w], mm_a[w], ffi_a[w]} !== '0) begin
        n_bad++;
        $display("FAIL reset inst%0d outputs busy=%b done=%b pass=%b v=%b in=%0d tab=%h cnt=%0d idx=%0d want all 0",
                 w, busy_v[w], done_v[w], pass_v[w], ffv_v[w], dut_in_a[w], table_a[w], mm_a[w], ffi_a[w]);
      end
    end
    $display("reset: outputs checked on 3 instances");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_majority;
    launch(0, 8'hE8, 1);
    watch_sweep(0, 1, 0, 8'h00, "majority_s1");
  endtask

  task automatic test_stuck;
    stuck = 1'b1;
    launch(0, 8'hE8, 1);
    watch_sweep(0, 1, 0, 8'h00, "stuck0");
    stuck = 1'b0;
  endtask

  task automatic test_settle;
    launch(1, 8'hE8, 1);
    watch_sweep(1, 3, 0, 8'h00, "majority_s3");
    launch(2, 8'hE8, 1);
    watch_sweep(2, 0, 0, 8'h00, "majority_s0");
  endtask

  task automatic test_restart;
    launch(0, 8'hE8, 1);
    watch_sweep(0, 1, 5, 8'h17, "restart_midsweep");
  endtask

  task automatic test_abort;
    bit seen_done;
    launch(0, 8'hE8, 0);
    for (int c = 1; c < 11; c++) @(negedge clk);
    n_cmp++;
    if (dut_in_a[0] !== 3'd5) begin
      n_bad++;
      $display("FAIL abort pre dut_in got=%0d want=5", dut_in_a[0]);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++;
    if (busy_v[0] !== 1'b0 || dut_in_a[0] !== 3'd0 || done_v[0] !== 1'b0 || pass_v[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL abort state busy=%b in=%0d done=%b pass=%b want 0/0/0/0",
               busy_v[0], dut_in_a[0], done_v[0], pass_v[0]);
    end
    n_cmp++;
    if (table_a[0][4:0] !== 5'b01000 || mm_a[0] !== 4'd0) begin
      n_bad++;
      $display("FAIL abort partial tab[4:0]=%b cnt=%0d want 01000 cnt=0", table_a[0][4:0], mm_a[0]);
    end
    seen_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done_v[0] || busy_v[0]) seen_done = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (seen_done) begin
      n_bad++;
      $display("FAIL abort idle got=activity want=none");
    end
    $display("abort: at dut_in=5, partial tab=%b", table_a[0][4:0]);
    launch(0, 8'hE8, 1);
    watch_sweep(0, 1, 0, 8'h00, "after_abort");
  endtask

  task automatic test_reset_midsweep;
    launch(0, 8'hE8, 0);
    for (int c = 1; c < 13; c++) @(negedge clk);
    n_cmp++;
    if (dut_in_a[0] !== 3'd6) begin
      n_bad++;
      $display("FAIL rst_mid pre dut_in got=%0d want=6", dut_in_a[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy_v[0], done_v[0], pass_v[0], ffv_v[0], dut_in_a[0], table_a[0], mm_a[0], ffi_a[0]} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid outputs busy=%b in=%0d tab=%h cnt=%0d want all 0",
               busy_v[0], dut_in_a[0], table_a[0], mm_a[0]);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("rst_mid: reset applied at dut_in=6");
    launch(0, 8'hE8, 1);
    watch_sweep(0, 1, 0, 8'h00, "after_reset");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_majority();
    test_stuck();
    test_settle();
    test_restart();
    test_abort();
    test_reset_midsweep();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard leftover got=%0d want=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencer that exhaustively exercises a small combinational function block, such as a 3-input x/y/z -> f gate network.
- Drives every input combination in ascending order, waits a settle time, samples the output and builds the observed truth table.
- Compares the observed table against an expected table and reports pass/fail plus the first failing vector.
- Sits between a lab control/status interface and the gate-level function block under exercise.

Parameters:
N_IN, 3, number of function inputs; sweep covers 2**N_IN vectors
SETTLE, 1, extra hold cycles per vector before sampling; legal range 0..15

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  request a sweep; honoured only in IDLE
abort  input  1  cancel a sweep in progress
expected  input  2**N_IN  expected truth table; bit i = f for input vector i
dut_in  output  N_IN  drive to function inputs; MSB = x, LSB = z for N_IN=3
dut_f  input  1  function output being checked
busy  output  1  sweep in progress
done  output  1  one-cycle pulse when a sweep completes normally
table_out  output  2**N_IN  observed table; bit i = dut_f sampled for vector i
pass  output  1  table_out == latched expected, valid from done until next start
mismatch_cnt  output  N_IN+1  number of differing bits
first_fail_idx  output  N_IN  lowest failing vector index; 0 if none
first_fail_valid  output  1  at least one mismatch recorded

Behaviour:
- Reset, in any state: state=IDLE; every output 0, including dut_in, busy, done, table_out, pass, mismatch_cnt, first_fail_idx and first_fail_valid. Hold counter and latched expected cleared.
- States: IDLE, HOLD, SAMPLE, FINISH.
- IDLE:
  - start=1 at an edge latches expected and clears table_out, mismatch_cnt, first_fail_* and pass.
  - Same edge: dut_in<=0, busy<=1, hold counter<=SETTLE. Goes to HOLD if SETTLE>0, else directly to SAMPLE.
- HOLD: counter decrements each cycle; moves to SAMPLE on the edge where the counter reaches 0.
- SAMPLE, at the edge ending the cycle:
  - table_out[dut_in]<=dut_f.
  - On mismatch with expected_latched[dut_in]: mismatch_cnt increments. If first_fail_valid=0, set first_fail_idx=dut_in and first_fail_valid=1.
  - If dut_in == 2**N_IN-1: go to FINISH.
  - Otherwise: dut_in increments, counter reloads with SETTLE, go to HOLD (SAMPLE if SETTLE=0).
- Each vector is therefore held exactly SETTLE+1 cycles, and dut_f is sampled on the last of them.
- FINISH (1 cycle):
  - done=1, busy=0, pass = (mismatch_cnt==0); dut_in returns to 0 on the following edge.
  - Returns to IDLE. Results hold until the next accepted start.
- Timing: with start accepted at edge 0, busy is high for 2**N_IN*(SETTLE+1) cycles and done is high in the following cycle.
  - N_IN=3, SETTLE=1: busy for cycles 1..16, done in cycle 17.
- start while busy or in FINISH: ignored, with no effect on the sweep.
- abort=1 in HOLD/SAMPLE:
  - Next edge: IDLE, busy=0, dut_in=0, no done pulse, pass=0. Partial table_out and mismatch data are retained.
  - abort has priority over a SAMPLE-state update on the same edge.
- abort in IDLE/FINISH: no effect. start and abort both high in IDLE: start wins.
- expected changing mid-sweep: no effect, because the latched copy is used.
- dut_in only changes on clock edges, so it is glitch-free toward the function block.

Test Plan:
- Majority model (f = xy|yz|xz), expected=8'hE8, SETTLE=1, start pulse: busy 16 cycles, done in cycle 17, table_out=8'hE8, pass=1, mismatch_cnt=0, first_fail_valid=0.
- dut_f stuck at 0, expected=8'hE8: table_out=8'h00, mismatch_cnt=4, first_fail_idx=3, first_fail_valid=1, pass=0.
- SETTLE=3 with majority model: each dut_in value held 4 cycles, done in cycle 33 after start, pass=1. Repeat with SETTLE=0: done in cycle 9.
- start re-asserted at cycle 5 and expected changed mid-sweep: sweep unaffected, single done at cycle 17, pass judged against the original expected.
- abort asserted while dut_in=5: next cycle busy=0, dut_in=0, done never pulses, table_out bits 0..4 retained. A new start then runs a full 16-cycle sweep.
- rst asserted while dut_in=6: next cycle all outputs 0 and state IDLE. A subsequent start completes a normal sweep with correct results.
